// File: rtl/dac_mixer_pkg.sv
// Shared mixer types, default sizes and the saturation helper used by every mix point.
package dac_mixer_pkg;

   localparam int unsigned DAC_MIXER_CHANNELS = 9;
   localparam int unsigned DAC_GAIN_WIDTH     = 8;
   localparam int unsigned DAC_GAIN_UNITY     = 1 << (DAC_GAIN_WIDTH - 1);
   localparam int unsigned DAC_FIFO_DEPTH     = 4;
   localparam int unsigned DAC_WIDTH          = 24;

   typedef struct packed {
      logic signed [DAC_WIDTH-1:0] l;
      logic signed [DAC_WIDTH-1:0] r;
   } stereo_sample_t;

   // Clamp a wide signed value into a signed range of the given width.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                   input int unsigned        width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (val > hi) begin
         return hi;
      end else if (val < lo) begin
         return lo;
      end
      return val;
   endfunction

endpackage

// File: rtl/dac_mixer_fifo.sv
// Single-clock show-ahead FIFO; a pop frees the slot for a push in the same cycle.
module dac_mixer_fifo
   import dac_mixer_pkg::*;
#(
   parameter int unsigned Depth    = DAC_FIFO_DEPTH,
   parameter type         sample_t = stereo_sample_t
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  sample_t wdata_i,
   output logic    full_o,
   input  logic    pop_i,
   output sample_t rdata_o,
   output logic    empty_o
);

   localparam int unsigned Aw = $clog2(Depth);

   sample_t       mem_q [Depth];
   logic [Aw:0]   wr_ptr_q, wr_ptr_d;
   logic [Aw:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) &&
                    (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/dac_mixer.sv
// Stereo DAC mixer: per-slot L/R gain, per-frame accumulation, saturation and a frame FIFO.
module dac_mixer
   import dac_mixer_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS     = DAC_MIXER_CHANNELS,
   parameter int unsigned SAMPLE_WIDTH     = 16,
   parameter int unsigned GAIN_WIDTH       = DAC_GAIN_WIDTH,
   parameter int unsigned DAC_OUTPUT_WIDTH = DAC_WIDTH,
   parameter int unsigned DAC_LEFT_SHIFT   = 4,
   parameter int unsigned FIFO_DEPTH       = DAC_FIFO_DEPTH
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               channel_valid,
   input  logic [$clog2(NUM_CHANNELS)-1:0]    channel_idx,
   input  logic signed [SAMPLE_WIDTH-1:0]     channel_sample,
   input  logic                               frame_end,
   input  logic                               cfg_wr,
   input  logic [$clog2(NUM_CHANNELS)-1:0]    cfg_idx,
   input  logic [GAIN_WIDTH-1:0]              cfg_gain_l,
   input  logic [GAIN_WIDTH-1:0]              cfg_gain_r,
   output logic                               sample_valid,
   input  logic                               sample_ready,
   output logic signed [DAC_OUTPUT_WIDTH-1:0] sample_l,
   output logic signed [DAC_OUTPUT_WIDTH-1:0] sample_r,
   output logic                               clip,
   output logic                               overrun,
   input  logic                               status_clr
);

   localparam int unsigned IdxW  = $clog2(NUM_CHANNELS);
   localparam int unsigned AccW  = SAMPLE_WIDTH + 2 + IdxW;
   localparam int unsigned ProdW = SAMPLE_WIDTH + GAIN_WIDTH + 1;
   localparam logic [GAIN_WIDTH-1:0] GainUnity = {1'b1, {(GAIN_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic signed [DAC_OUTPUT_WIDTH-1:0] l;
      logic signed [DAC_OUTPUT_WIDTH-1:0] r;
   } frame_t;

   logic [GAIN_WIDTH-1:0]  gain_l_q [NUM_CHANNELS];
   logic [GAIN_WIDTH-1:0]  gain_r_q [NUM_CHANNELS];
   logic [GAIN_WIDTH-1:0]  g_l, g_r;
   logic signed [ProdW-1:0] full_l, full_r;
   logic signed [AccW-1:0] prod_l_d, prod_r_d, prod_l_q, prod_r_q;
   logic signed [AccW-1:0] sum_l_d, sum_r_d, sum_l_q, sum_r_q;
   logic signed [AccW-1:0] acc_l_d, acc_r_d, acc_l_q, acc_r_q;
   logic signed [63:0]     wide_l, wide_r, sat_l, sat_r;
   logic                   valid1_q, fe1_q, fe2_q, push_q, clip3_q, clip_any;
   logic                   clip_q, clip_d, overrun_q, overrun_d;
   logic                   fifo_full, fifo_empty;
   frame_t                 frame_d, frame_q, head, last_q;

   // Gains are read combinationally before the edge that writes them: old gain wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            gain_l_q[i] <= GainUnity;
            gain_r_q[i] <= GainUnity;
         end
      end else if (cfg_wr && (32'(cfg_idx) < NUM_CHANNELS)) begin
         gain_l_q[cfg_idx] <= cfg_gain_l;
         gain_r_q[cfg_idx] <= cfg_gain_r;
      end
   end

   always_comb begin
      g_l = '0;
      g_r = '0;
      if (32'(channel_idx) < NUM_CHANNELS) begin
         g_l = gain_l_q[channel_idx];
         g_r = gain_r_q[channel_idx];
      end
      full_l   = ProdW'(channel_sample) * ProdW'($signed({1'b0, g_l}));
      full_r   = ProdW'(channel_sample) * ProdW'($signed({1'b0, g_r}));
      prod_l_d = AccW'(full_l >>> (GAIN_WIDTH - 1));
      prod_r_d = AccW'(full_r >>> (GAIN_WIDTH - 1));
   end

   always_comb begin
      sum_l_d = acc_l_q + (valid1_q ? prod_l_q : '0);
      sum_r_d = acc_r_q + (valid1_q ? prod_r_q : '0);
      acc_l_d = fe1_q ? '0 : sum_l_d;
      acc_r_d = fe1_q ? '0 : sum_r_d;
   end

   always_comb begin
      wide_l    = 64'(sum_l_q) <<< DAC_LEFT_SHIFT;
      wide_r    = 64'(sum_r_q) <<< DAC_LEFT_SHIFT;
      sat_l     = saturate(wide_l, DAC_OUTPUT_WIDTH);
      sat_r     = saturate(wide_r, DAC_OUTPUT_WIDTH);
      clip_any  = (sat_l != wide_l) || (sat_r != wide_r);
      frame_d.l = DAC_OUTPUT_WIDTH'(sat_l);
      frame_d.r = DAC_OUTPUT_WIDTH'(sat_r);
   end

   // Sets take priority over a coincident clear.
   always_comb begin
      clip_d    = (clip_q && !status_clr) || clip3_q;
      overrun_d = (overrun_q && !status_clr) || (push_q && fifo_full && !sample_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid1_q  <= 1'b0;
         fe1_q     <= 1'b0;
         prod_l_q  <= '0;
         prod_r_q  <= '0;
         acc_l_q   <= '0;
         acc_r_q   <= '0;
         fe2_q     <= 1'b0;
         sum_l_q   <= '0;
         sum_r_q   <= '0;
         push_q    <= 1'b0;
         clip3_q   <= 1'b0;
         frame_q   <= '0;
         last_q    <= '0;
         clip_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         valid1_q  <= channel_valid;
         fe1_q     <= frame_end;
         prod_l_q  <= prod_l_d;
         prod_r_q  <= prod_r_d;
         acc_l_q   <= acc_l_d;
         acc_r_q   <= acc_r_d;
         fe2_q     <= fe1_q;
         if (fe1_q) begin
            sum_l_q <= sum_l_d;
            sum_r_q <= sum_r_d;
         end
         push_q    <= fe2_q;
         clip3_q   <= fe2_q && clip_any;
         if (fe2_q) frame_q <= frame_d;
         if (sample_valid && sample_ready) last_q <= head;
         clip_q    <= clip_d;
         overrun_q <= overrun_d;
      end
   end

   dac_mixer_fifo #(
      .Depth    (FIFO_DEPTH),
      .sample_t (frame_t)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push_q),
      .wdata_i (frame_q),
      .full_o  (fifo_full),
      .pop_i   (sample_ready),
      .rdata_o (head),
      .empty_o (fifo_empty)
   );

   // An empty FIFO keeps presenting the last frame the consumer took.
   assign sample_valid = !fifo_empty;
   assign sample_l     = fifo_empty ? last_q.l : head.l;
   assign sample_r     = fifo_empty ? last_q.r : head.r;
   assign clip         = clip_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_dac_mixer.sv
// Directed bench for dac_mixer built with a 16-bit DAC output so clipping is reachable.
module tb_dac_mixer;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              channel_valid;
   logic [3:0]        channel_idx;
   logic signed [15:0] channel_sample;
   logic              frame_end;
   logic              cfg_wr;
   logic [3:0]        cfg_idx;
   logic [7:0]        cfg_gain_l;
   logic [7:0]        cfg_gain_r;
   logic              sample_valid;
   logic              sample_ready;
   logic signed [15:0] sample_l;
   logic signed [15:0] sample_r;
   logic              clip;
   logic              overrun;
   logic              status_clr;

   int n_tests = 0;
   int n_fail  = 0;

   dac_mixer #(
      .DAC_OUTPUT_WIDTH (16)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .channel_valid  (channel_valid),
      .channel_idx    (channel_idx),
      .channel_sample (channel_sample),
      .frame_end      (frame_end),
      .cfg_wr         (cfg_wr),
      .cfg_idx        (cfg_idx),
      .cfg_gain_l     (cfg_gain_l),
      .cfg_gain_r     (cfg_gain_r),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .sample_l       (sample_l),
      .sample_r       (sample_r),
      .clip           (clip),
      .overrun        (overrun),
      .status_clr     (status_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slot(input int idx, input int s, input bit fe);
      channel_valid  = 1'b1;
      channel_idx    = 4'(idx);
      channel_sample = 16'(s);
      frame_end      = fe;
      tick();
      channel_valid  = 1'b0;
      frame_end      = 1'b0;
   endtask

   task automatic frame9(input int s);
      for (int i = 0; i < 9; i++) slot(i, s, i == 8);
   endtask

   task automatic set_gain(input int idx, input int gl, input int gr);
      cfg_wr     = 1'b1;
      cfg_idx    = 4'(idx);
      cfg_gain_l = 8'(gl);
      cfg_gain_r = 8'(gr);
      tick();
      cfg_wr     = 1'b0;
   endtask

   // Called one cycle after frame_end; returns in the cycle the frame should be visible,
   // optionally pulsing status_clr / sample_ready on the cycle the frame enters the FIFO.
   task automatic finish_frame(input bit clr_c3, input bit rdy_c3);
      tick();
      tick();
      status_clr   = clr_c3;
      sample_ready = rdy_c3;
      tick();
      status_clr   = 1'b0;
      sample_ready = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input int l, input int r);
      check({tag, ".valid"}, 32'(sample_valid), 1);
      check({tag, ".l"}, 32'(sample_l), l);
      check({tag, ".r"}, 32'(sample_r), r);
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 12 && !sample_valid; i++) tick();
      check({tag, ".arrive"}, 32'(sample_valid), 1);
   endtask

   initial begin
      reset_n = 1'b0;
      channel_valid = 1'b0; channel_idx = '0; channel_sample = '0; frame_end = 1'b0;
      cfg_wr = 1'b0; cfg_idx = '0; cfg_gain_l = '0; cfg_gain_r = '0;
      sample_ready = 1'b0; status_clr = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      check("rst.valid", 32'(sample_valid), 0);
      check("rst.l", 32'(sample_l), 0);
      check("rst.r", 32'(sample_r), 0);
      check("rst.clip", 32'(clip), 0);
      check("rst.overrun", 32'(overrun), 0);

      // Unity mix of nine slots, exact latency
      frame9(100);
      tick();
      tick();
      check("lat.c3_valid", 32'(sample_valid), 0);
      tick();
      expect_frame("unity", 14400, 14400);
      check("unity.clip", 32'(clip), 0);
      check("unity.hold_valid", 32'(sample_valid), 0);
      check("unity.hold_l", 32'(sample_l), 14400);

      // Per-slot gain
      set_gain(2, 0, 255);
      slot(2, 1000, 1'b1);
      finish_frame(1'b0, 1'b0);
      expect_frame("gain2", 0, 31872);
      set_gain(2, 128, 128);

      // Out-of-range slot contributes nothing; empty frame yields zeros
      slot(0, 100, 1'b0);
      slot(10, 1000, 1'b1);
      finish_frame(1'b0, 1'b0);
      expect_frame("badidx", 1600, 1600);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      finish_frame(1'b0, 1'b0);
      expect_frame("empty", 0, 0);

      // Saturation and sticky clip
      frame9(32767);
      finish_frame(1'b0, 1'b0);
      expect_frame("satpos", 32767, 32767);
      check("satpos.clip", 32'(clip), 1);
      frame9(-32768);
      finish_frame(1'b1, 1'b0);
      check("clrset.clip", 32'(clip), 1);
      expect_frame("satneg", -32768, -32768);
      slot(0, 100, 1'b1);
      finish_frame(1'b1, 1'b0);
      check("clean_clr.clip", 32'(clip), 0);
      expect_frame("clean", 1600, 1600);

      // Overrun: five frames into a four-deep FIFO
      for (int k = 1; k <= 5; k++) slot(0, 10 * k, 1'b1);
      repeat (8) tick();
      check("ovr.flag", 32'(overrun), 1);
      for (int k = 1; k <= 4; k++) expect_frame($sformatf("ovr.f%0d", k), 160 * k, 160 * k);
      check("ovr.drained", 32'(sample_valid), 0);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      check("ovr.clr", 32'(overrun), 0);

      // Full FIFO with a pop on the push cycle: no drop
      for (int k = 1; k <= 4; k++) slot(0, k, 1'b1);
      repeat (8) tick();
      slot(0, 5, 1'b1);
      finish_frame(1'b0, 1'b1);
      check("fullpop.overrun", 32'(overrun), 0);
      for (int k = 2; k <= 5; k++) expect_frame($sformatf("fullpop.f%0d", k), 16 * k, 16 * k);

      // Gain write racing a sample on the same slot, then an out-of-range write
      cfg_wr = 1'b1; cfg_idx = 4'd3; cfg_gain_l = 8'd64; cfg_gain_r = 8'd0;
      slot(3, 1000, 1'b1);
      cfg_wr = 1'b0;
      finish_frame(1'b0, 1'b0);
      expect_frame("rbw.old", 16000, 16000);
      slot(3, 1000, 1'b1);
      finish_frame(1'b0, 1'b0);
      expect_frame("rbw.new", 8000, 0);
      set_gain(12, 0, 0);
      slot(3, 1000, 1'b1);
      finish_frame(1'b0, 1'b0);
      expect_frame("cfg12", 8000, 0);

      // Reset mid-frame with a frame buffered
      slot(0, 100, 1'b1);
      finish_frame(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) slot(i, 100, 1'b0);
      reset_n = 1'b0;
      #1;
      check("midrst.valid", 32'(sample_valid), 0);
      check("midrst.l", 32'(sample_l), 0);
      tick();
      reset_n = 1'b1;
      tick();
      frame9(50);
      wait_valid("postrst");
      expect_frame("postrst", 7200, 7200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dac_mixer.md
Name: dac_mixer

Overview:
Parametrised successor to the single-channel DAC prep stage.
- Accepts time-multiplexed per-channel samples from the operator pipeline.
- Applies a per-channel left/right gain and accumulates each sample period into a stereo frame.
- Saturates each frame to DAC width and buffers it in a small output FIFO with a valid/ready handshake toward the DAC or host logic.
- Single clock domain; any CDC is the consumer's job.

Parameters:
NUM_CHANNELS, 9, number of channel slots per frame
SAMPLE_WIDTH, 16, signed input sample width
GAIN_WIDTH, 8, unsigned gain width; value 2^(GAIN_WIDTH-1) = unity
DAC_OUTPUT_WIDTH, 24, signed output sample width
DAC_LEFT_SHIFT, 4, arithmetic left shift applied to the mixed sum before saturation
FIFO_DEPTH, 4, output frame buffer depth (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
channel_valid  in  1  channel_sample/channel_idx valid this cycle
channel_idx  in  $clog2(NUM_CHANNELS)  slot of current sample
channel_sample  in  SAMPLE_WIDTH  signed channel sample
frame_end  in  1  pulse: last sample of current frame has been presented (may coincide with channel_valid)
cfg_wr  in  1  gain write strobe
cfg_idx  in  $clog2(NUM_CHANNELS)  gain slot to write
cfg_gain_l  in  GAIN_WIDTH  left gain
cfg_gain_r  in  GAIN_WIDTH  right gain
sample_valid  out  1  FIFO head holds a frame
sample_ready  in  1  consumer accepts head when sample_valid high
sample_l  out  DAC_OUTPUT_WIDTH  signed left output
sample_r  out  DAC_OUTPUT_WIDTH  signed right output
clip  out  1  sticky: a frame saturated
overrun  out  1  sticky: a frame was dropped because the FIFO was full
status_clr  in  1  clears clip and overrun

Behaviour:
- Reset (async assert, sync release): pipeline, accumulators and FIFO empty. sample_valid=0, sample_l=sample_r=0, clip=overrun=0. All gains = unity (2^(GAIN_WIDTH-1)).
- Gain RAM:
  - One register pair per slot, written on cfg_wr.
  - cfg_idx >= NUM_CHANNELS is ignored.
  - Read-before-write: a sample on the same slot in the same cycle as a write uses the old gain.
- Stage 1 (registered products):
  - prod_l = (channel_sample * gain_l) >>> (GAIN_WIDTH-1), signed x unsigned with full-precision product; prod_r likewise.
  - Samples with channel_idx >= NUM_CHANNELS are zeroed.
  - frame_end is delayed with the data.
- Stage 2 (accumulate):
  - acc width = SAMPLE_WIDTH+2+$clog2(NUM_CHANNELS); must never wrap.
  - Duplicate slots within a frame are summed, not deduplicated.
  - On the delayed frame_end, frame sum = acc + current product (if valid). acc is then loaded with 0, so the next frame starts clean with no lost or doubled sample.
- Stage 3 (saturate):
  - shifted = sum <<< DAC_LEFT_SHIFT, computed at full width.
  - Clamp to [-2^(DAC_OUTPUT_WIDTH-1), 2^(DAC_OUTPUT_WIDTH-1)-1] per side.
  - Any clamp sets clip.
- Latency: frame_end high in cycle 0 with FIFO empty -> sample_valid high from cycle 4 with that frame on sample_l/sample_r.
- Empty frame: frame_end with no valid samples produces a 0/0 frame.
- FIFO:
  - Show-ahead; sample_l/r are stable while sample_valid && !sample_ready.
  - Pop on sample_valid && sample_ready.
  - Push when full: the new frame is dropped, head is unchanged, overrun is set.
  - Push and pop in the same cycle when full: the pop frees the slot and the push succeeds, no overrun.
  - When empty, sample_l/r hold the last popped value.
- Sticky flags: a set in the same cycle as status_clr wins.
- Reset mid-frame: the partial frame and all buffered frames are discarded and gains return to unity.

Decomposition:
- opl2_pkg additions:
  - constants DAC_MIXER_CHANNELS, DAC_GAIN_WIDTH, DAC_GAIN_UNITY, DAC_FIFO_DEPTH
  - typedef stereo_sample_t {l, r}
  - function saturate(), reused by other mix points
- One sub-module: mixer_fifo, a parametrised single-clock show-ahead FIFO of stereo_sample_t with full/empty, simultaneous push/pop, and async active-low reset.
- Gain RAM, pipeline and accumulators stay in dac_mixer.

Test Plan:
- Unity gains; slots 0..8 carry sample 100, frame_end with slot 8 -> one frame, l=r=900<<<4=14400, arriving cycle 4 after frame_end; clip=0.
- cfg slot 2 to l=0, r=255; slot 2 sample 1000 alone in frame -> l=0, r=(1000*255>>>7)<<<4=31872.
- Nine slots at +32767 with DAC_OUTPUT_WIDTH=16 -> l=r=32767, clip=1. status_clr coincident with another clipping frame -> clip stays 1. Next clean frame plus clr -> clip=0.
- sample_ready held 0, 5 frames pushed with FIFO_DEPTH=4 -> frames 1-4 retained in order, frame 5 dropped, overrun=1. Full with ready=1 and push same cycle -> no overrun.
- Same-cycle cfg_wr and sample on slot 3 -> that sample uses the old gain, the next frame uses the new gain. cfg_idx=12 -> no change.
- reset_n pulsed low mid-frame after 4 samples -> sample_valid=0 immediately. Next full frame after release contains only post-reset samples.
